// File: rtl/jamma_joy_mux_if.sv
// Board-side bundle for the JAMMA joystick/coin mux.
// master = harness/board side, slave = the mux itself.
interface jamma_joy_mux_if;
   logic [7:0] jjoy;
   logic [5:0] local_joy;
   logic [1:0] jcoin_n;
   logic       jselect;
   logic [7:0] joy1;
   logic [7:0] joy2;
   logic [1:0] coin_n;
   logic       scan_done;

   modport master (
      output jjoy,
      output local_joy,
      output jcoin_n,
      input  jselect,
      input  joy1,
      input  joy2,
      input  coin_n,
      input  scan_done
   );

   modport slave (
      input  jjoy,
      input  local_joy,
      input  jcoin_n,
      output jselect,
      output joy1,
      output joy2,
      output coin_n,
      output scan_done
   );
endinterface

// File: rtl/jamma_joy_mux.sv
// Time-multiplexed JAMMA joystick sampler with coin pulse stretcher.
// Define JAMMA_JOY_DEBOUNCE_EN to enable per-player sample debouncing.
module jamma_joy_mux #(
   parameter int PHASE_CYCLES  = 128,
   parameter int SETTLE_CYCLES = 16,
   parameter int DEBOUNCE_CNT  = 4,
   parameter int COIN_HOLD     = 4096
) (
   input logic            clk,
   input logic            reset,
   jamma_joy_mux_if.slave bus
);

   localparam int PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
   localparam int CW = (COIN_HOLD > 1) ? $clog2(COIN_HOLD) : 1;

   localparam logic [PW-1:0] PH_LAST = PW'(PHASE_CYCLES - 1);
   localparam logic [PW-1:0] PH_SMP  = PW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LD = CW'(COIN_HOLD - 1);

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES >= PHASE_CYCLES) begin : g_bad_settle
      $error("SETTLE_CYCLES must be 1..PHASE_CYCLES-1");
   end
   if (DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 15) begin : g_bad_deb
      $error("DEBOUNCE_CNT must be 1..15");
   end
   if (COIN_HOLD < 1) begin : g_bad_hold
      $error("COIN_HOLD must be at least 1");
   end

   logic [PW-1:0] phase;
   logic          sel;
   logic          scan;
   logic          take;
   logic [7:0]    smp;
   logic [1:0]    hit;
   logic [7:0]    joy [2];

   assign take = (phase == PH_SMP);
   assign smp  = sel ? bus.jjoy : (bus.jjoy & {2'b11, bus.local_joy});
   assign hit  = {take & sel, take & ~sel};

   always_ff @(posedge clk) begin
      if (reset) begin
         phase <= '0;
         sel   <= 1'b0;
         scan  <= 1'b0;
      end else begin
         scan <= hit[1];
         if (phase == PH_LAST) begin
            phase <= '0;
            sel   <= ~sel;
         end else begin
            phase <= phase + PW'(1);
         end
      end
   end

`ifdef JAMMA_JOY_DEBOUNCE_EN
   localparam logic [3:0] DEB = 4'(DEBOUNCE_CNT);

   logic [7:0] cand    [2];
   logic [7:0] cand_nx [2];
   logic [3:0] mcnt    [2];
   logic [3:0] mcnt_nx [2];

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         cand_nx[p] = cand[p];
         mcnt_nx[p] = mcnt[p];
         if (hit[p]) begin
            if (smp != cand[p]) begin
               cand_nx[p] = smp;
               mcnt_nx[p] = 4'd1;
            end else if (mcnt[p] != DEB) begin
               mcnt_nx[p] = mcnt[p] + 4'd1;
            end
         end
      end
   end

   // output follows the candidate on the same edge the run completes
   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (reset) begin
            cand[p] <= 8'hFF;
            mcnt[p] <= 4'd0;
            joy[p]  <= 8'hFF;
         end else begin
            cand[p] <= cand_nx[p];
            mcnt[p] <= mcnt_nx[p];
            if (hit[p] && mcnt_nx[p] == DEB) begin
               joy[p] <= cand_nx[p];
            end
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (reset) begin
            joy[p] <= 8'hFF;
         end else if (hit[p]) begin
            joy[p] <= smp;
         end
      end
   end
`endif

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HOLD     = 2'd1,
      WAIT_REL = 2'd2
   } coin_st_t;

   coin_st_t      cst     [2];
   coin_st_t      cst_nx  [2];
   logic [CW-1:0] ccnt    [2];
   logic [CW-1:0] ccnt_nx [2];
   logic [1:0]    s1;
   logic [1:0]    s2;
   logic [1:0]    s_prev;
   logic [1:0]    fall;
   logic [1:0]    coin_q;
   logic [1:0]    coin_nx;

   assign fall = s_prev & ~s2;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1     <= 2'b11;
         s2     <= 2'b11;
         s_prev <= 2'b11;
      end else begin
         s1     <= bus.jcoin_n;
         s2     <= s1;
         s_prev <= s2;
      end
   end

   always_comb begin
      for (int b = 0; b < 2; b++) begin
         cst_nx[b]  = cst[b];
         ccnt_nx[b] = ccnt[b];
         unique case (cst[b])
            IDLE: begin
               if (fall[b]) begin
                  cst_nx[b]  = HOLD;
                  ccnt_nx[b] = HOLD_LD;
               end
            end
            HOLD: begin
               if (ccnt[b] == '0) begin
                  cst_nx[b] = WAIT_REL;
               end else begin
                  ccnt_nx[b] = ccnt[b] - CW'(1);
               end
            end
            WAIT_REL: begin
               if (s2[b]) begin
                  cst_nx[b] = IDLE;
               end
            end
            default: cst_nx[b] = IDLE;
         endcase
         coin_nx[b] = (cst_nx[b] != HOLD);
      end
   end

   // coin_n is registered off the next state so it never glitches
   always_ff @(posedge clk) begin
      for (int b = 0; b < 2; b++) begin
         if (reset) begin
            cst[b]  <= IDLE;
            ccnt[b] <= '0;
         end else begin
            cst[b]  <= cst_nx[b];
            ccnt[b] <= ccnt_nx[b];
         end
      end
      if (reset) begin
         coin_q <= 2'b11;
      end else begin
         coin_q <= coin_nx;
      end
   end

   assign bus.jselect   = sel;
   assign bus.joy1      = joy[0];
   assign bus.joy2      = joy[1];
   assign bus.coin_n    = coin_q;
   assign bus.scan_done = scan;

endmodule

// File: tb/tb_jamma_joy_mux.sv
// Random-stimulus bench for jamma_joy_mux against a timeline model.
// Honours JAMMA_JOY_DEBOUNCE_EN the same way the design does.
module tb_jamma_joy_mux;
   localparam int P = 8;
   localparam int S = 3;
   localparam int D = 3;
   localparam int H = 5;
   localparam int NCYC = 6000;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   jamma_joy_mux_if bus();

   jamma_joy_mux #(
      .PHASE_CYCLES (P),
      .SETTLE_CYCLES(S),
      .DEBOUNCE_CNT (D),
      .COIN_HOLD    (H)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [7:0] got,
                        input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   int         cyc;
   logic [7:0] h0[$];
   logic [7:0] h1[$];
   logic [1:0] rawlog [NCYC + 8];
   int         t_edge [2];
   bit         armed  [2];
   logic       e_jsel;
   logic       e_scan;
   logic [7:0] e_joy1;
   logic [7:0] e_joy2;
   logic [1:0] e_coin;

   function automatic logic [1:0] sync_at(input int c);
      return (c >= 2) ? rawlog[c - 2] : 2'b11;
   endfunction

`ifdef JAMMA_JOY_DEBOUNCE_EN
   function automatic bit settled(input logic [7:0] q[$]);
      if (q.size() < D) return 1'b0;
      foreach (q[i]) if (q[i] != q[0]) return 1'b0;
      return 1'b1;
   endfunction
`endif

   // expected outputs after the coming edge, from this cycle's inputs
   task automatic model_step();
      logic [7:0] smp;
      logic [1:0] sc;
      logic [1:0] sp;
      bit         sel;
      if (reset) begin
         cyc = 0;
         h0.delete();
         h1.delete();
         e_jsel = 1'b0;
         e_scan = 1'b0;
         e_joy1 = 8'hFF;
         e_joy2 = 8'hFF;
         e_coin = 2'b11;
         for (int b = 0; b < 2; b++) begin
            t_edge[b] = -1000;
            armed[b]  = 1'b1;
         end
      end else begin
         sel    = ((cyc / P) % 2) == 1;
         e_scan = 1'b0;
         if (cyc % P == S - 1) begin
            if (sel) begin
               smp = bus.jjoy;
               h1.push_back(smp);
               if (h1.size() > D) void'(h1.pop_front());
               e_scan = 1'b1;
`ifdef JAMMA_JOY_DEBOUNCE_EN
               if (settled(h1)) e_joy2 = smp;
`else
               e_joy2 = smp;
`endif
            end else begin
               smp = bus.jjoy & {2'b11, bus.local_joy};
               h0.push_back(smp);
               if (h0.size() > D) void'(h0.pop_front());
`ifdef JAMMA_JOY_DEBOUNCE_EN
               if (settled(h0)) e_joy1 = smp;
`else
               e_joy1 = smp;
`endif
            end
         end
         rawlog[cyc] = bus.jcoin_n;
         sc = sync_at(cyc);
         sp = sync_at(cyc - 1);
         for (int b = 0; b < 2; b++) begin
            if (armed[b] && sp[b] && !sc[b]) begin
               t_edge[b] = cyc;
               armed[b]  = 1'b0;
            end else if (!armed[b] && cyc > t_edge[b] + H && sc[b]) begin
               armed[b] = 1'b1;
            end
            e_coin[b] = !(cyc >= t_edge[b] && cyc < t_edge[b] + H);
         end
         cyc++;
         e_jsel = ((cyc / P) % 2) == 1;
      end
   endtask

   initial begin
      int rst_left;
      int mode;
      rst_left      = 0;
      reset         = 1'b1;
      bus.jjoy      = 8'hFF;
      bus.local_joy = 6'h3F;
      bus.jcoin_n   = 2'b11;
      model_step();
      for (int n = 0; n < NCYC; n++) begin
         @(posedge clk);
         #1;
         check("jselect", 8'(bus.jselect), 8'(e_jsel));
         check("scan_done", 8'(bus.scan_done), 8'(e_scan));
         check("joy1", bus.joy1, e_joy1);
         check("joy2", bus.joy2, e_joy2);
         check("coin_n", 8'(bus.coin_n), 8'(e_coin));

         if (n < 3) begin
            reset = 1'b1;
         end else if (rst_left > 0) begin
            reset = 1'b1;
            rst_left--;
         end else if ($urandom_range(0, 399) == 0) begin
            reset    = 1'b1;
            rst_left = $urandom_range(0, 2);
         end else begin
            reset = 1'b0;
         end

         mode = (n / 600) % 3;
         case (mode)
            0: if ($urandom_range(0, 99) == 0) bus.jjoy = 8'($urandom);
            1: bus.jjoy = 8'($urandom);
            default: bus.jjoy = {7'h7F, 1'((n / 16) % 2)};
         endcase
         if ($urandom_range(0, 199) == 0) bus.local_joy = 6'($urandom);
         for (int b = 0; b < 2; b++) begin
            if ($urandom_range(0, 9) == 0) bus.jcoin_n[b] = ~bus.jcoin_n[b];
         end
         model_step();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/jamma_joy_mux.md
JAMMA_JOY_MUX -- requirements
Module: jamma_joy_mux

Interface
REQ-001 Parameter PHASE_CYCLES, default 128: clocks per select half-period.
REQ-002 Parameter SETTLE_CYCLES, default 16: clocks after a select change before sampling; legal range 1..PHASE_CYCLES-1.
REQ-003 Parameter DEBOUNCE_CNT, default 4: consecutive identical samples required before a player output updates; legal range 1..15.
REQ-004 Parameter COIN_HOLD, default 4096: minimum low time of a stretched coin pulse, in clocks.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 jjoy  input  8  shared JAMMA joystick bus, active-low; [7] is the start button.
REQ-008 local_joy  input  6  on-board joystick, active-low, merged into player 1.
REQ-009 jcoin_n  input  2  raw coin switches, active-low, asynchronous.
REQ-010 jselect  output  1  external mux select; 0 selects player 1, 1 selects player 2.
REQ-011 joy1  output  8  conditioned player 1 bus, active-low.
REQ-012 joy2  output  8  conditioned player 2 bus, active-low.
REQ-013 coin_n  output  2  stretched coin pulses, active-low.
REQ-014 scan_done  output  1  one-clock strobe marking a completed player-2 sample.

Function
REQ-015 The phase counter shall count 0..PHASE_CYCLES-1; at terminal count it shall wrap to 0 and jselect shall toggle on the same edge.
REQ-016 When the phase counter equals SETTLE_CYCLES-1, a sample shall be taken: with jselect=0 the sample is jjoy & {2'b11, local_joy} and goes to player 1; with jselect=1 the sample is jjoy and goes to player 2.
REQ-017 Each player shall hold a candidate register and a 4-bit match count.
REQ-018 On a sample equal to the candidate, the match count shall increment, saturating at DEBOUNCE_CNT.
REQ-019 On a sample unequal to the candidate, the candidate shall load the sample and the match count shall be set to 1.
REQ-020 When the match count reaches DEBOUNCE_CNT, the player output shall load the candidate on the next clock.
REQ-021 Worst-case latency from a stable jjoy change to the output is DEBOUNCE_CNT*2*PHASE_CYCLES+1 clocks.
REQ-022 scan_done shall pulse high for exactly one clock, on the clock after each player-2 sample.
REQ-023 Each jcoin_n bit shall pass through a 2-flop synchronizer.
REQ-024 Coin path states, per bit: IDLE, HOLD, WAIT_REL.
REQ-025 IDLE to HOLD on a synchronized falling edge; coin_n goes low and the hold counter loads COIN_HOLD-1.
REQ-026 HOLD to WAIT_REL when the counter reaches 0; coin_n returns high.
REQ-027 WAIT_REL to IDLE when the synchronized input is high.
REQ-028 Edges occurring during HOLD or WAIT_REL shall be ignored.
REQ-029 The two coin bits shall be fully independent; simultaneous edges shall produce simultaneous pulses.

Reset
REQ-030 While reset is high, the following shall hold on every clock: jselect=0, phase counter=0, joy1=joy2=8'hFF, candidates=8'hFF, match counts=0, scan_done=0, coin_n=2'b11, coin states=IDLE, synchronizers=1.
REQ-031 Reset asserted mid-phase or mid-HOLD shall abort immediately with no residual pulse; the first sample after release occurs SETTLE_CYCLES clocks later, with jselect=0.

Configuration
REQ-032 With macro JAMMA_JOY_DEBOUNCE_EN defined, REQ-017..REQ-020 apply.
REQ-033 With JAMMA_JOY_DEBOUNCE_EN undefined, the player output shall load each sample on the clock after it is taken, with no candidate or match logic; DEBOUNCE_CNT is ignored.

Verification (PHASE_CYCLES=8, SETTLE_CYCLES=3, DEBOUNCE_CNT=3, COIN_HOLD=5)
REQ-034 Release reset -> jselect toggles at clocks 8, 16, 24...; player-1 samples at clock 2, player-2 samples at clock 10; scan_done is high at clock 11 only.
REQ-035 jjoy held at 8'hFE, local_joy=6'h3F, debounce on -> joy1=8'hFE after the third player-1 sample, at clock 35; joy2 identical at clock 43.
REQ-036 jjoy toggles bit 0 every sample -> joy1 and joy2 stay 8'hFF indefinitely; with the macro undefined, they follow each sample one clock later.
REQ-037 jjoy=8'hFF, local_joy=6'h3D -> joy1=8'hFD and joy2=8'hFF.
REQ-038 jcoin_n[0] low for 2 clocks -> coin_n[0] low for exactly 5 clocks, starting 3 clocks after the edge; a second edge inside the hold produces no extra pulse.
REQ-039 Reset asserted at clock 12 during a coin hold -> coin_n=2'b11, joy1=joy2=8'hFF, and jselect=0 on the next clock.
